alu_issue_ctrl: RTL and testbench

//  Requester-side front end for the 16-bit combinational ALU (3-bit ALU_Control).

---
 rtl/alu_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue front end for a 16-bit combinational ALU: decodes opcode/funct, registers the
// operands, captures Result/Zero and returns them on a valid/ready response channel.
// Optional statistics counters are built when ALU_STATS_EN is defined.
module alu_issue_ctrl #(
   parameter int WIDTH  = 16,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_opcode,
   input  logic [2:0]        req_funct,
   input  logic [WIDTH-1:0]  req_a,
   input  logic [WIDTH-1:0]  req_b,
   input  logic [WIDTH-1:0]  req_imm,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [2:0]        alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WIDTH-1:0]  rsp_result,
   output logic              rsp_zero,
   output logic              rsp_err,
   output logic [STAT_W-1:0] stat_ops,
   output logic [STAT_W-1:0] stat_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [2:0]         alu_ctrl_q, alu_ctrl_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic               rsp_zero_q, rsp_zero_d;
   logic               rsp_err_q, rsp_err_d;

   logic               dec_legal, dec_use_imm, accept, rsp_hs;
   logic [2:0]         dec_ctrl;

   always_comb begin
      dec_legal   = 1'b1;
      dec_use_imm = 1'b0;
      dec_ctrl    = req_funct;
      case (req_opcode)
         4'b0000: dec_ctrl = req_funct;
         4'b0001: begin dec_ctrl = 3'b000; dec_use_imm = 1'b1; end
         4'b0010: begin dec_ctrl = 3'b101; dec_use_imm = 1'b1; end
         4'b0011: begin dec_ctrl = 3'b110; dec_use_imm = 1'b1; end
         4'b0100: begin dec_ctrl = 3'b111; dec_use_imm = 1'b1; end
         4'b0101: dec_ctrl = 3'b001;
         default: begin dec_legal = 1'b0; dec_ctrl = 3'b000; end
      endcase
   end

   // A response slot frees up in the same cycle it drains, so RESP can accept directly.
   assign req_ready = (state_q == IDLE) | ((state_q == RESP) & rsp_ready);
   assign accept    = req_valid & req_ready;
   assign rsp_hs    = rsp_valid_q & rsp_ready;

   always_comb begin
      state_d      = state_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_ctrl_d   = alu_ctrl_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = 1'b0;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: ;
      endcase
      if (accept) begin
         if (dec_legal) begin
            alu_a_d     = req_a;
            alu_b_d     = dec_use_imm ? req_imm : req_b;
            alu_ctrl_d  = dec_ctrl;
            rsp_valid_d = 1'b0;
            state_d     = EXEC;
         end else begin
            // Illegal ops bypass the ALU and answer one cycle after accept.
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            state_d      = RESP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_ctrl_q   <= 3'b000;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_ctrl_q   <= alu_ctrl_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_ctrl   = alu_ctrl_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;

`ifdef ALU_STATS_EN
   logic [STAT_W-1:0] stat_ops_q, stat_ops_d, stat_zero_q, stat_zero_d;

   // Counters saturate at all-ones rather than wrapping.
   always_comb begin
      stat_ops_d  = stat_ops_q;
      stat_zero_d = stat_zero_q;
      if (rsp_hs && !(&stat_ops_q))
         stat_ops_d = stat_ops_q + STAT_W'(1);
      if (rsp_hs && rsp_zero_q && !(&stat_zero_q))
         stat_zero_d = stat_zero_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ops_q  <= '0;
         stat_zero_q <= '0;
      end else begin
         stat_ops_q  <= stat_ops_d;
         stat_zero_q <= stat_zero_d;
      end
   end

   assign stat_ops  = stat_ops_q;
   assign stat_zero = stat_zero_q;
`else
   logic unused_hs;
   assign unused_hs = rsp_hs;
   assign stat_ops  = '0;
   assign stat_zero = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural 16-bit ALU attached.
module tb_alu_issue_ctrl;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready;
   logic [3:0]    req_opcode;
   logic [2:0]    req_funct;
   logic [W-1:0]  req_a, req_b, req_imm;
   logic [W-1:0]  alu_a, alu_b, alu_result;
   logic [2:0]    alu_ctrl;
   logic          alu_zero;
   logic          rsp_valid, rsp_ready, rsp_zero, rsp_err;
   logic [W-1:0]  rsp_result;
   logic [15:0]   stat_ops, stat_zero;

   int            n_cmp = 0;
   int            n_err = 0;
   int            tb_ops = 0;
   int            tb_zero = 0;
   logic [17:0]   sb[$];

   alu_issue_ctrl #(.WIDTH(W), .STAT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_funct(req_funct),
      .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .stat_ops(stat_ops), .stat_zero(stat_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      case (c)
         3'd0: alu_fn = a + b;
         3'd1: alu_fn = a - b;
         3'd2: alu_fn = ~a;
         3'd3: alu_fn = a << b;
         3'd4: alu_fn = a >> b;
         3'd5: alu_fn = a & b;
         3'd6: alu_fn = a | b;
         default: alu_fn = {{(W-1){1'b0}}, (a < b)};
      endcase
   endfunction

   assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);
   assign alu_zero   = (alu_result == '0);

   // Expected response {err, zero, result} from the request itself.
   function automatic logic [17:0] model(input logic [3:0] op, input logic [2:0] fn,
                                         input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] imm);
      logic [2:0]   c;
      logic [W-1:0] bb, r;
      c = fn; bb = b;
      case (op)
         4'd0: begin c = fn;   bb = b;   end
         4'd1: begin c = 3'd0; bb = imm; end
         4'd2: begin c = 3'd5; bb = imm; end
         4'd3: begin c = 3'd6; bb = imm; end
         4'd4: begin c = 3'd7; bb = imm; end
         4'd5: begin c = 3'd1; bb = b;   end
         default: return {1'b1, 1'b0, 16'h0000};
      endcase
      r = alu_fn(c, a, bb);
      return {1'b0, (r == '0), r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin : mon
      logic [17:0] e;
      if (!rst_n) begin
         tb_ops  = 0;
         tb_zero = 0;
      end else if (rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_rsp", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("rsp_err", rsp_err, e[17]);
            chk("rsp_zero", rsp_zero, e[16]);
            chk("rsp_result", rsp_result, e[15:0]);
            tb_ops++;
            if (rsp_zero) tb_zero++;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the accepting edge.
   task automatic send(input logic [3:0] op, input logic [2:0] fn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] imm, input bit rnd);
      bit done;
      done = 0;
      req_valid = 1'b1; req_opcode = op; req_funct = fn;
      req_a = a; req_b = b; req_imm = imm;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (req_ready) begin
            sb.push_back(model(op, fn, a, b, imm));
            done = 1;
         end
         @(posedge clk); #1;
         if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      end
      req_valid = 1'b0;
      if (!done) chk("accept_timeout", 0, 1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      req_opcode = '0; req_funct = '0; req_a = '0; req_b = '0; req_imm = '0;
      #3;
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_ctrl", alu_ctrl, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_stat_ops", stat_ops, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // R-type add with overflow into the sign bit
      send(4'h0, 3'd0, 16'h7FFF, 16'h0001, 16'h0000, 0);
      @(negedge clk);
      chk("add_lat_n1", rsp_valid, 0);
      chk("add_ctrl", alu_ctrl, 3'b000);
      @(negedge clk);
      chk("add_lat_n2", rsp_valid, 1);
      @(posedge clk); #1;

      send(4'h5, 3'd0, 16'h1234, 16'h1234, 16'h0000, 0);
      @(negedge clk);
      chk("beq_ctrl", alu_ctrl, 3'b001);
      @(posedge clk); #1;
      @(posedge clk); #1;

      send(4'h4, 3'd0, 16'h0003, 16'hFFFF, 16'h0005, 0);
      @(negedge clk);
      chk("slti_alu_b", alu_b, 16'h0005);
      chk("slti_ctrl", alu_ctrl, 3'b111);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Illegal opcode answers at N+1 and leaves the ALU inputs untouched
      send(4'hF, 3'd2, 16'hAAAA, 16'hBBBB, 16'hCCCC, 0);
      @(negedge clk);
      chk("ill_lat_n1", rsp_valid, 1);
      chk("ill_alu_a", alu_a, 16'h0003);
      chk("ill_alu_b", alu_b, 16'h0005);
      chk("ill_alu_ctrl", alu_ctrl, 3'b111);
      @(posedge clk); #1;

      // Back-pressure: hold rsp_ready low and check the response stays put
      rsp_ready = 1'b0;
      send(4'h3, 3'd0, 16'h00F0, 16'h0000, 16'h0F00, 0);
      @(negedge clk);
      @(negedge clk);
      chk("stall_valid_n2", rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1);
         chk("stall_result", rsp_result, 16'h0FF0);
         chk("stall_req_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      send(4'h0, 3'd1, 16'h0001, 16'h0002, 16'h0000, 0);
      @(negedge clk);
      chk("drain_acc_n1", rsp_valid, 0);
      @(negedge clk);
      chk("drain_acc_n2", rsp_valid, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++)
         send(4'($urandom_range(0, 7)), 3'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;

      // Reset while the op is in EXEC discards it
      send(4'h1, 3'd0, 16'h0010, 16'h0000, 16'h0020, 0);
      rst_n = 1'b0;
      #1;
      chk("rstx_rsp_valid", rsp_valid, 0);
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rstx_req_ready", req_ready, 1);
      chk("rstx_valid_after", rsp_valid, 0);
      @(posedge clk); #1;

      send(4'h0, 3'd0, 16'h0001, 16'h0002, 16'h0000, 0);
      send(4'h5, 3'd0, 16'h5555, 16'h5555, 16'h0000, 0);
      send(4'h3, 3'd0, 16'h0100, 16'h0000, 16'h0001, 0);
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_done", sb.size(), 0);
      @(negedge clk);
`ifdef ALU_STATS_EN
      chk("stat_ops", stat_ops, tb_ops);
      chk("stat_zero", stat_zero, tb_zero);
      chk("stat_ops_post_rst", tb_ops, 3);
`else
      chk("stat_ops_off", stat_ops, 0);
      chk("stat_zero_off", stat_zero, 0);
      chk("ops_post_rst", tb_ops, 3);
`endif
      chk("zero_post_rst", tb_zero, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
